serial_subtractor: RTL and testbench

- Bit-serial, LSB-first subtractor computing A - B over WIDTH clock cycles using one shared full-subtractor cell and a borrow flip-flop.
- Complements the combinational adder path: the arithmetic section uses it for area-cheap subtraction where latency is acceptable.
- Start/Ready request handshake in, single-cycle Done pulse out; results held stable until the next accepted request.

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encodings and width default for the serial subtractor
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int SUB_WIDTH_DEF = 4;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational full subtractor cell
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  // difference bit and borrow-out for A - B - Bin
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first A - B (optional Zero flag via SERIAL_SUB_ZERO_FLAG_EN)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Done
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             Zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             a_msb;
  logic             b_msb;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             br_nxt;
  logic             accept;
  logic             last_shift;

  assign accept     = Start && Ready;
  assign last_shift = (cnt == CW'(WIDTH - 1));

  // single shared cell; operands are always the current LSBs
  full_subtractor u_fs (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Bin  (br),
    .D    (d_bit),
    .Bout (br_nxt)
  );

  // state register
  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state: SHIFT runs exactly WIDTH cycles, DONE lasts one
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Ready is a pure decode of IDLE
  always_comb begin
    Ready = (state == ST_IDLE);
  end

  // datapath: capture, shift, and publish results only when leaving DONE
  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      br     <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Ovf    <= 1'b0;
      Done   <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      Zero   <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            br     <= 1'b0;
            cnt    <= '0;
          end
        end
        ST_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          br     <= br_nxt;
          cnt    <= cnt + 1'b1;
        end
        ST_DONE: begin
          Diff <= res_sh;
          Bout <= br;
          Ovf  <= (a_msb != b_msb) && (res_sh[WIDTH-1] != a_msb);
          Done <= 1'b1;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
          Zero <= (res_sh == '0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  logic       Clk;
  logic       Rst;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Ready;
  logic [3:0] Diff;
  logic       Bout;
  logic       Ovf;
  logic       Done;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic       Zero;
`endif

  int total;
  int bad;

  serial_subtractor #(.WIDTH(4)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Ready (Ready),
    .Diff  (Diff),
    .Bout  (Bout),
    .Ovf   (Ovf),
    .Done  (Done)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    .Zero  (Zero)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // issue one request, scramble inputs after acceptance, return edges until Done (-1 on timeout)
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat);
    @(negedge Clk);
    A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; A = ~a; B = ~b;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (Done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b1; Start = 1'b1; A = 4'd7; B = 4'd1;
    repeat (2) @(posedge Clk);
    #1;
    Start = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    total++; if (Ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", Ready); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", Done); end
    total++; if (Diff !== 4'd0) begin bad++; $display("FAIL reset_diff got=%h exp=0", Diff); end
    total++; if (Bout !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b exp=0", Bout); end
    total++; if (Ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", Ovf); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    total++; if (Zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", Zero); end
`endif
  endtask

  task automatic test_basic();
    int lat;
    run_op(4'd7, 4'd3, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    total++; if (Diff !== 4'd4) begin bad++; $display("FAIL basic_diff got=%h exp=4", Diff); end
    total++; if (Bout !== 1'b0) begin bad++; $display("FAIL basic_bout got=%b exp=0", Bout); end
    total++; if (Ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", Ovf); end
    total++; if (Ready !== 1'b1) begin bad++; $display("FAIL basic_ready_at_done got=%b exp=1", Ready); end
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      total++; if (Diff !== 4'd4 || Done !== 1'b0 || Ready !== 1'b1) begin
        bad++; $display("FAIL basic_hold cyc=%0d diff=%h done=%b ready=%b exp diff=4 done=0 ready=1", i, Diff, Done, Ready);
      end
    end
  endtask

  task automatic test_borrow();
    int lat;
    @(negedge Clk);
    A = 4'd3; B = 4'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; A = 4'hF; B = 4'h0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge Clk); #1;
      total++; if (Diff !== 4'd4 || Done !== 1'b0 || Ready !== 1'b0) begin
        bad++; $display("FAIL borrow_shift_hold cyc=%0d diff=%h done=%b ready=%b exp diff=4 done=0 ready=0", i, Diff, Done, Ready);
      end
    end
    lat = -1;
    for (int i = 5; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (Done) begin lat = i; break; end
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL borrow_latency got=%0d exp=5", lat); end
    total++; if (Diff !== 4'b1100) begin bad++; $display("FAIL borrow_diff got=%b exp=1100", Diff); end
    total++; if (Bout !== 1'b1) begin bad++; $display("FAIL borrow_bout got=%b exp=1", Bout); end
    total++; if (Ovf !== 1'b0) begin bad++; $display("FAIL borrow_ovf got=%b exp=0", Ovf); end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(4'b1000, 4'd1, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL ovf_latency got=%0d exp=5", lat); end
    total++; if (Diff !== 4'b0111) begin bad++; $display("FAIL ovf_diff got=%b exp=0111", Diff); end
    total++; if (Bout !== 1'b0) begin bad++; $display("FAIL ovf_bout got=%b exp=0", Bout); end
    total++; if (Ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", Ovf); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    total++; if (Zero !== 1'b0) begin bad++; $display("FAIL ovf_zero got=%b exp=0", Zero); end
`endif
    // back-to-back: issue the next request on the first Ready edge
    run_op(4'd5, 4'd5, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL equal_latency got=%0d exp=5", lat); end
    total++; if (Diff !== 4'd0) begin bad++; $display("FAIL equal_diff got=%h exp=0", Diff); end
    total++; if (Bout !== 1'b0) begin bad++; $display("FAIL equal_bout got=%b exp=0", Bout); end
    total++; if (Ovf !== 1'b0) begin bad++; $display("FAIL equal_ovf got=%b exp=0", Ovf); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    total++; if (Zero !== 1'b1) begin bad++; $display("FAIL equal_zero got=%b exp=1", Zero); end
`endif
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [3:0] diff_at_done;
    @(negedge Clk);
    A = 4'd9; B = 4'd2; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    A = 4'd1; B = 4'd1; Start = 1'b1;
    total++; if (Ready !== 1'b0) begin bad++; $display("FAIL ignore_ready got=%b exp=0", Ready); end
    @(posedge Clk); #1;
    Start = 1'b0;
    total++; if (Ready !== 1'b0) begin bad++; $display("FAIL ignore_ready_after got=%b exp=0", Ready); end
    dones = 0;
    diff_at_done = 4'hX;
    for (int i = 0; i < 14; i++) begin
      if (Done) begin dones++; diff_at_done = Diff; end
      @(posedge Clk); #1;
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    total++; if (diff_at_done !== 4'd7) begin bad++; $display("FAIL ignore_diff got=%h exp=7", diff_at_done); end
    total++; if (Ovf !== 1'b1) begin bad++; $display("FAIL ignore_ovf got=%b exp=1", Ovf); end
  endtask

  task automatic test_reset_abort();
    int dones;
    int lat;
    @(negedge Clk);
    A = 4'd6; B = 4'd1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    total++; if (Ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", Ready); end
    total++; if (Diff !== 4'd0 || Bout !== 1'b0 || Ovf !== 1'b0) begin
      bad++; $display("FAIL abort_outputs diff=%h bout=%b ovf=%b exp 0 0 0", Diff, Bout, Ovf);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done) dones++;
      @(posedge Clk); #1;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_done_count got=%0d exp=0", dones); end
    run_op(4'd6, 4'd1, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL abort_retry_latency got=%0d exp=5", lat); end
    total++; if (Diff !== 4'd5) begin bad++; $display("FAIL abort_retry_diff got=%h exp=5", Diff); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    Rst = 1'b1;
    Start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_ignore_start();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
